hps_io_initiator: RTL and testbench



---
 rtl/hps_io_initiator.sv | 173 +++++++++++++++++
 tb/tb_hps_io_initiator.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hps_io_initiator.sv
// hps_io_initiator: host-side master for the HPS strobe/ack word protocol.
// Takes a command (select + word count), then for each word loads io_din,
// raises io_clk, waits for the responder's io_ack, captures io_dout, drops
// io_clk, and waits for io_ack to fall before the next word.
// Ports:
//   clk_sys, reset_n          clock, async active-low reset
//   cmd_valid/ready, cmd_sel, cmd_len   command handshake (sel 3 = reserved, len 0 = 16)
//   wr_valid/ready, wr_data   per-word write data
//   rd_valid, rd_data         per-word captured io_dout (one-cycle pulse)
//   done, err                 end-of-command pulses (err = timeout or reserved sel)
//   io_din, io_clk, io_uio/io_fpga/io_osd   protocol outputs
//   io_ack, io_dout           protocol inputs (io_ack asynchronous)
module hps_io_initiator #(
  parameter int TIMEOUT = 65535,
  parameter int SETUP   = 2,
  parameter int GAP     = 2
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_sel,
  input  logic [3:0]  cmd_len,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [15:0] wr_data,
  output logic        rd_valid,
  output logic [15:0] rd_data,
  output logic        done,
  output logic        err,
  output logic [15:0] io_din,
  output logic        io_clk,
  output logic        io_uio,
  output logic        io_fpga,
  output logic        io_osd,
  input  logic        io_ack,
  input  logic [15:0] io_dout
);

  typedef enum logic [2:0] {IDLE, SELECT, LOAD, STB_HI, STB_LO, RELEASE} state_t;

  localparam int          TW       = 17;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [7:0]  SETUP_LAST = 8'(SETUP - 1);
  localparam logic [7:0]  GAP_LAST   = 8'(GAP - 1);

  state_t        state;
  logic [TW-1:0] tmo;
  logic [7:0]    dly;
  logic [4:0]    words;
  logic [2:0]    sel_oh;   // {osd, fpga, uio}
  logic          ack_m, ack_s;

  assign io_uio  = sel_oh[0];
  assign io_fpga = sel_oh[1];
  assign io_osd  = sel_oh[2];

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ack_m <= 1'b0;
      ack_s <= 1'b0;
    end else begin
      ack_m <= io_ack;
      ack_s <= ack_m;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      tmo       <= '0;
      dly       <= '0;
      words     <= '0;
      sel_oh    <= '0;
      cmd_ready <= 1'b0;
      wr_ready  <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      io_din    <= '0;
      io_clk    <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            if (cmd_sel == 2'd3) begin
              err <= 1'b1;          // reserved target: reject, stay ready
            end else begin
              cmd_ready <= 1'b0;
              sel_oh    <= 3'b001 << cmd_sel;
              words     <= (cmd_len == 4'd0) ? 5'd16 : {1'b0, cmd_len};
              dly       <= '0;
              state     <= SELECT;
            end
          end
        end
        SELECT: begin
          if (dly == SETUP_LAST) begin
            wr_ready <= 1'b1;
            state    <= LOAD;
          end else begin
            dly <= dly + 8'd1;
          end
        end
        LOAD: begin
          // No timeout here: the host may stall the write stream indefinitely.
          // The strobe is held off while a stray ack is still visible.
          if (wr_valid && wr_ready && !ack_s) begin
            io_din   <= wr_data;
            wr_ready <= 1'b0;
            io_clk   <= 1'b1;
            tmo      <= '0;
            state    <= STB_HI;
          end
        end
        STB_HI: begin
          if (ack_s) begin
            rd_data  <= io_dout;
            rd_valid <= 1'b1;
            io_clk   <= 1'b0;
            tmo      <= '0;
            state    <= STB_LO;
          end else if (tmo == TMO_LAST) begin
            io_clk <= 1'b0;
            sel_oh <= '0;
            err    <= 1'b1;
            dly    <= '0;
            state  <= RELEASE;
          end else begin
            tmo <= (&tmo) ? tmo : tmo + 1'b1;
          end
        end
        STB_LO: begin
          // Only the low level matters; a re-rise of ack here is ignored.
          if (!ack_s) begin
            words <= words - 5'd1;
            if (words == 5'd1) begin
              sel_oh <= '0;
              done   <= 1'b1;
              dly    <= '0;
              state  <= RELEASE;
            end else begin
              wr_ready <= 1'b1;
              state    <= LOAD;
            end
          end else if (tmo == TMO_LAST) begin
            sel_oh <= '0;
            err    <= 1'b1;
            dly    <= '0;
            state  <= RELEASE;
          end else begin
            tmo <= (&tmo) ? tmo : tmo + 1'b1;
          end
        end
        RELEASE: begin
          if (dly == GAP_LAST) begin
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end else begin
            dly <= dly + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hps_io_initiator.sv
// Directed bench for hps_io_initiator with a small behavioural responder
// and a passive monitor that counts strobes, reads, done/err pulses and
// protocol rule breaks.
module tb_hps_io_initiator;

  logic        clk_sys, reset_n;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_sel;
  logic [3:0]  cmd_len;
  logic        wr_valid, wr_ready;
  logic [15:0] wr_data;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        done, err;
  logic [15:0] io_din;
  logic        io_clk, io_uio, io_fpga, io_osd;
  logic        io_ack;
  logic [15:0] io_dout;

  hps_io_initiator #(.TIMEOUT(100), .SETUP(2), .GAP(2)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sel(cmd_sel), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .err(err),
    .io_din(io_din), .io_clk(io_clk), .io_uio(io_uio), .io_fpga(io_fpga), .io_osd(io_osd),
    .io_ack(io_ack), .io_dout(io_dout)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  int n_cmp = 0, n_bad = 0;

  // Responder: acks resp_delay cycles after seeing io_clk, releases once io_clk falls.
  logic        resp_en, resp_fixed;
  logic [15:0] resp_val;
  int          resp_delay;
  int          rs, rcnt;
  always @(negedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rs <= 0; rcnt <= 0; io_ack <= 1'b0; io_dout <= 16'h0;
    end else begin
      case (rs)
        0: if (resp_en && io_clk) begin rcnt <= resp_delay; rs <= 1; end
        1: if (rcnt <= 1) begin
             io_dout <= resp_fixed ? resp_val : (io_din ^ 16'h5A5A);
             io_ack  <= 1'b1;
             rs      <= 2;
           end else rcnt <= rcnt - 1;
        default: if (!io_clk) begin io_ack <= 1'b0; rs <= 0; end
      endcase
    end
  end

  // Monitor
  int          rise_cnt = 0, rd_cnt = 0, done_cnt = 0, err_cnt = 0, sel_cyc = 0;
  int          din_viol = 0, oh_viol = 0, sel_at_done = 0, ack_at_done = 0, clk_ack_viol = 0;
  int          hi_run = 0, last_hi_run = 0;
  logic        clk_prev = 1'b0;
  logic [15:0] din_prev = 16'h0, last_din_rise = 16'h0;
  logic [15:0] rd_log [0:63];
  always @(negedge clk_sys) begin
    clk_prev <= io_clk;
    din_prev <= io_din;
    if (io_clk && !clk_prev) begin
      rise_cnt <= rise_cnt + 1;
      last_din_rise <= io_din;
      if (io_ack) clk_ack_viol <= clk_ack_viol + 1;
    end
    if (io_clk && clk_prev && io_din !== din_prev) din_viol <= din_viol + 1;
    if (io_clk) hi_run <= hi_run + 1;
    else begin
      if (hi_run != 0) last_hi_run <= hi_run;
      hi_run <= 0;
    end
    if (rd_valid) begin
      rd_log[rd_cnt[5:0]] <= rd_data;
      rd_cnt <= rd_cnt + 1;
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      if (io_uio | io_fpga | io_osd) sel_at_done <= sel_at_done + 1;
      if (io_ack) ack_at_done <= ack_at_done + 1;
    end
    if (err) err_cnt <= err_cnt + 1;
    if (io_uio | io_fpga | io_osd) sel_cyc <= sel_cyc + 1;
    if ((32'(io_uio) + 32'(io_fpga) + 32'(io_osd)) > 1) oh_viol <= oh_viol + 1;
  end

  task automatic send_cmd(input logic [1:0] s, input logic [3:0] l);
    int k = 0;
    @(negedge clk_sys);
    while (!cmd_ready && k < 500) begin @(negedge clk_sys); k++; end
    if (!cmd_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL cmd_accept: cmd_ready=0 after %0d cycles, want 1", k);
    end
    cmd_sel = s; cmd_len = l; cmd_valid = 1'b1;
    @(negedge clk_sys);
    cmd_valid = 1'b0;
  endtask

  task automatic write_word(input logic [15:0] d);
    int k = 0;
    while (!wr_ready && k < 1000) begin @(negedge clk_sys); k++; end
    if (!wr_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL wr_accept: wr_ready=0 after %0d cycles, want 1", k);
    end
    wr_data = d; wr_valid = 1'b1;
    @(negedge clk_sys);
    wr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (!cmd_ready && k < 2000) begin @(negedge clk_sys); k++; end
    if (!cmd_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL idle_wait: cmd_ready=0 after %0d cycles, want 1", k);
    end
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk_sys);
    n_cmp++;
    if ({cmd_ready, wr_ready, rd_valid, rd_data, done, err, io_din, io_clk, io_uio, io_fpga, io_osd} !== 41'd0) begin
      n_bad++; $display("FAIL reset_outs: outputs not all zero during reset, want 0");
    end
    reset_n = 1'b1;
    #1;
    n_cmp++;
    if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL ready_pre_edge: got %b want 0", cmd_ready); end
    @(negedge clk_sys);
    n_cmp++;
    if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL ready_first_edge: got %b want 1", cmd_ready); end
  endtask

  task automatic test_single();
    int r0 = rd_cnt, d0 = done_cnt, e0 = err_cnt, c0 = rise_cnt;
    resp_fixed = 1'b1; resp_val = 16'hBEEF; resp_delay = 3;
    send_cmd(2'd0, 4'd1);
    n_cmp++;
    if ({io_uio, io_fpga, io_osd} !== 3'b100) begin
      n_bad++; $display("FAIL single_sel: got %b want 100", {io_uio, io_fpga, io_osd});
    end
    write_word(16'h0001);
    wait_idle();
    n_cmp++;
    if (last_din_rise !== 16'h0001) begin n_bad++; $display("FAIL single_din: got %h want 0001", last_din_rise); end
    n_cmp++;
    if (rd_cnt - r0 != 1 || rd_log[r0[5:0]] !== 16'hBEEF) begin
      n_bad++; $display("FAIL single_rd: count %0d data %h want 1 beef", rd_cnt - r0, rd_log[r0[5:0]]);
    end
    n_cmp++;
    if (done_cnt - d0 != 1 || err_cnt - e0 != 0 || rise_cnt - c0 != 1) begin
      n_bad++; $display("FAIL single_counts: done %0d err %0d strobes %0d want 1 0 1", done_cnt - d0, err_cnt - e0, rise_cnt - c0);
    end
    n_cmp++;
    if ({io_uio, io_fpga, io_osd} !== 3'b000) begin n_bad++; $display("FAIL single_sel_off: got %b want 000", {io_uio, io_fpga, io_osd}); end
  endtask

  task automatic test_burst16();
    int r0 = rd_cnt, d0 = done_cnt, e0 = err_cnt, c0 = rise_cnt, bad = 0;
    resp_fixed = 1'b0; resp_delay = 2;
    send_cmd(2'd2, 4'd0);
    n_cmp++;
    if ({io_uio, io_fpga, io_osd} !== 3'b001) begin
      n_bad++; $display("FAIL burst_sel: got %b want 001", {io_uio, io_fpga, io_osd});
    end
    for (int i = 0; i < 16; i++) write_word(16'(i));
    wait_idle();
    n_cmp++;
    if (rise_cnt - c0 != 16 || rd_cnt - r0 != 16) begin
      n_bad++; $display("FAIL burst_counts: strobes %0d reads %0d want 16 16", rise_cnt - c0, rd_cnt - r0);
    end
    for (int i = 0; i < 16; i++) begin
      logic [5:0]  idx;
      logic [15:0] exp_v;
      idx = 6'(r0 + i);
      exp_v = 16'(i) ^ 16'h5A5A;
      if (rd_log[idx] !== exp_v) bad++;
    end
    n_cmp++;
    if (bad != 0) begin n_bad++; $display("FAIL burst_data: %0d bad words want 0", bad); end
    n_cmp++;
    if (done_cnt - d0 != 1 || err_cnt - e0 != 0) begin
      n_bad++; $display("FAIL burst_end: done %0d err %0d want 1 0", done_cnt - d0, err_cnt - e0);
    end
  endtask

  task automatic test_stall();
    int r0 = rd_cnt, d0 = done_cnt, e0 = err_cnt, k = 0, bad = 0;
    resp_fixed = 1'b0; resp_delay = 1;
    send_cmd(2'd1, 4'd2);
    write_word(16'h1234);
    while ((rd_cnt == r0 || !wr_ready) && k < 200) begin @(negedge clk_sys); k++; end
    n_cmp++;
    if (!wr_ready) begin n_bad++; $display("FAIL stall_reach_load: wr_ready %b want 1", wr_ready); end
    for (int i = 0; i < 50; i++) begin
      if (!io_fpga || io_clk || err) bad++;
      @(negedge clk_sys);
    end
    n_cmp++;
    if (bad != 0) begin n_bad++; $display("FAIL stall_hold: %0d bad cycles want 0", bad); end
    write_word(16'h5678);
    wait_idle();
    n_cmp++;
    if (done_cnt - d0 != 1 || err_cnt - e0 != 0 || rd_cnt - r0 != 2) begin
      n_bad++; $display("FAIL stall_end: done %0d err %0d reads %0d want 1 0 2", done_cnt - d0, err_cnt - e0, rd_cnt - r0);
    end
    n_cmp++;
    if (rd_log[6'(r0 + 1)] !== (16'h5678 ^ 16'h5A5A)) begin
      n_bad++; $display("FAIL stall_data: got %h want %h", rd_log[6'(r0 + 1)], 16'h5678 ^ 16'h5A5A);
    end
  endtask

  task automatic test_timeout();
    int d0 = done_cnt, e0 = err_cnt, k = 0, g = 0;
    resp_en = 1'b0;
    send_cmd(2'd0, 4'd1);
    write_word(16'hAAAA);
    while (!err && k < 300) begin @(negedge clk_sys); k++; end
    n_cmp++;
    if (!err || io_clk || io_uio || io_fpga || io_osd) begin
      n_bad++; $display("FAIL tmo_err: err %b clk %b sel %b want 1 0 000", err, io_clk, {io_uio, io_fpga, io_osd});
    end
    while (!cmd_ready && g < 20) begin @(negedge clk_sys); g++; end
    n_cmp++;
    if (g != 2) begin n_bad++; $display("FAIL tmo_gap: cmd_ready after %0d cycles want 2", g); end
    repeat (2) @(negedge clk_sys);
    n_cmp++;
    if (last_hi_run != 100) begin n_bad++; $display("FAIL tmo_clk_high: got %0d cycles want 100", last_hi_run); end
    n_cmp++;
    if (err_cnt - e0 != 1 || done_cnt - d0 != 0) begin
      n_bad++; $display("FAIL tmo_pulses: err %0d done %0d want 1 0", err_cnt - e0, done_cnt - d0);
    end
    resp_en = 1'b1;
  endtask

  task automatic test_reserved();
    int d0 = done_cnt, e0 = err_cnt, c0 = rise_cnt, s0 = sel_cyc;
    send_cmd(2'd3, 4'd1);
    repeat (5) @(negedge clk_sys);
    n_cmp++;
    if (err_cnt - e0 != 1 || done_cnt - d0 != 0) begin
      n_bad++; $display("FAIL rsv_pulses: err %0d done %0d want 1 0", err_cnt - e0, done_cnt - d0);
    end
    n_cmp++;
    if (rise_cnt - c0 != 0 || sel_cyc - s0 != 0) begin
      n_bad++; $display("FAIL rsv_quiet: strobes %0d sel cycles %0d want 0 0", rise_cnt - c0, sel_cyc - s0);
    end
  endtask

  task automatic test_reset_mid();
    int r0 = rd_cnt, d0, e0;
    resp_fixed = 1'b0; resp_delay = 3;
    send_cmd(2'd0, 4'd4);
    write_word(16'h0011);
    write_word(16'h0022);
    write_word(16'h0033);
    n_cmp++;
    if (!io_clk || rd_cnt - r0 != 2) begin
      n_bad++; $display("FAIL mid_word3: clk %b reads %0d want 1 2", io_clk, rd_cnt - r0);
    end
    d0 = done_cnt; e0 = err_cnt;
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({cmd_ready, wr_ready, rd_valid, rd_data, done, err, io_din, io_clk, io_uio, io_fpga, io_osd} !== 41'd0) begin
      n_bad++; $display("FAIL mid_async_clear: outputs not all zero, want 0");
    end
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_sys);
    n_cmp++;
    if (done_cnt != d0 || err_cnt != e0) begin
      n_bad++; $display("FAIL mid_no_pulse: done %0d err %0d extra, want 0 0", done_cnt - d0, err_cnt - e0);
    end
    r0 = rd_cnt;
    send_cmd(2'd0, 4'd1);
    write_word(16'h0F0F);
    wait_idle();
    n_cmp++;
    if (done_cnt - d0 != 1 || rd_cnt - r0 != 1 || rd_log[r0[5:0]] !== (16'h0F0F ^ 16'h5A5A)) begin
      n_bad++; $display("FAIL mid_recover: done %0d reads %0d data %h want 1 1 %h",
                        done_cnt - d0, rd_cnt - r0, rd_log[r0[5:0]], 16'h0F0F ^ 16'h5A5A);
    end
  endtask

  task automatic test_protocol();
    n_cmp++;
    if (din_viol != 0 || oh_viol != 0 || clk_ack_viol != 0) begin
      n_bad++; $display("FAIL proto_rules: din %0d onehot %0d clk_on_ack %0d want 0 0 0", din_viol, oh_viol, clk_ack_viol);
    end
    n_cmp++;
    if (sel_at_done != 0 || ack_at_done != 0) begin
      n_bad++; $display("FAIL proto_done: sel_at_done %0d ack_at_done %0d want 0 0", sel_at_done, ack_at_done);
    end
  endtask

  initial begin
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_sel = 2'd0; cmd_len = 4'd0;
    wr_valid = 1'b0; wr_data = 16'h0;
    resp_en = 1'b1; resp_fixed = 1'b1; resp_val = 16'hBEEF; resp_delay = 3;
    test_reset();
    test_single();
    test_burst16();
    test_stall();
    test_timeout();
    test_reserved();
    test_reset_mid();
    test_protocol();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
